// File: rtl/pot_pkg.sv
// rtl/pot_pkg.sv - shared FSM state type and POT exponent limit helper
//
// Purpose: common definitions for the power-of-two weight encoder.
//   state_t   : encoder FSM states (IDLE, SEARCH, DONE)
//   pot_emax  : largest exponent codable in a WEIGHT_BIT_WIDTH-bit POT code
package pot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // One bit of the code is the sign, the rest hold the exponent.
  function automatic int pot_emax(input int weight_bit_width);
    return (1 << (weight_bit_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/pot_round.sv
// rtl/pot_round.sv - round-to-nearest-POT and saturation decision
//
// Purpose: given a magnitude and the index of its leading one, produce the
// rounded, saturated exponent.
// Ports:
//   i_mag [IN_BIT_WIDTH-1:0]     unsigned magnitude
//   i_e   [IW-1:0]               index of the leading one of i_mag
//   o_exp [WEIGHT_BIT_WIDTH-2:0] rounded exponent, clipped to EMAX
//   o_sat                        exponent was clipped
module pot_round
  import pot_pkg::*;
#(
  parameter int IN_BIT_WIDTH     = 12,
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int IW               = $clog2(IN_BIT_WIDTH)
) (
  input  logic [IN_BIT_WIDTH-1:0]     i_mag,
  input  logic [IW-1:0]               i_e,
  output logic [WEIGHT_BIT_WIDTH-2:0] o_exp,
  output logic                        o_sat
);

  localparam int EMAX = pot_emax(WEIGHT_BIT_WIDTH);
  localparam int EW   = WEIGHT_BIT_WIDTH - 1;

  logic          w_half;
  logic          w_tail;
  logic          w_up;
  logic [IW:0]   w_er;

  always_comb begin
    w_half = 1'b0;
    w_tail = 1'b0;
    // w_half is the bit just below the leading one; w_tail ORs everything
    // further down. Rounding up needs both, so exact midpoints go down.
    for (int i = 0; i < IN_BIT_WIDTH; i++) begin
      if (i + 1 == int'(i_e)) w_half = i_mag[i];
      if (i + 2 <= int'(i_e)) w_tail = w_tail | i_mag[i];
    end
    w_up = (int'(i_e) >= 2) && w_half && w_tail;
    w_er = {1'b0, i_e} + (IW + 1)'(w_up);
    if (int'(w_er) > EMAX) begin
      o_exp = EW'(EMAX);
      o_sat = 1'b1;
    end else begin
      o_exp = EW'(w_er);
      o_sat = 1'b0;
    end
  end

endmodule

// File: rtl/pot_weight_encoder.sv
// rtl/pot_weight_encoder.sv - serial leading-one search POT weight encoder
//
// Purpose: encodes a two's-complement value as sign*2^e (nearest power of
// two, ties down), scanning one bit per cycle from the MSB.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_data   input handshake and signed value
//   out_valid/out_ready      output handshake
//   out_weight               {sign, exponent}
//   out_zero                 input was zero, out_weight = 0
//   out_sat                  exponent was clipped to EMAX
module pot_weight_encoder
  import pot_pkg::*;
#(
  parameter int IN_BIT_WIDTH     = 12,
  parameter int WEIGHT_BIT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_BIT_WIDTH-1:0]     in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WEIGHT_BIT_WIDTH-1:0] out_weight,
  output logic                        out_zero,
  output logic                        out_sat
);

  localparam int IW = $clog2(IN_BIT_WIDTH);

  state_t                        r_state;
  state_t                        w_next;
  logic                          r_sign;
  logic [IN_BIT_WIDTH-1:0]       r_mag;
  logic [IW-1:0]                 r_idx;
  logic [WEIGHT_BIT_WIDTH-1:0]   r_weight;
  logic                          r_zero;
  logic                          r_sat;
  logic [IN_BIT_WIDTH-1:0]       w_abs;
  logic [WEIGHT_BIT_WIDTH-2:0]   w_exp;
  logic                          w_sat;
  logic                          w_hit;

  // Negating -2^(N-1) wraps to itself, which read unsigned is 2^(N-1).
  assign w_abs = in_data[IN_BIT_WIDTH-1] ? (~in_data + IN_BIT_WIDTH'(1)) : in_data;
  assign w_hit = r_mag[r_idx];

  pot_round #(
    .IN_BIT_WIDTH    (IN_BIT_WIDTH),
    .WEIGHT_BIT_WIDTH(WEIGHT_BIT_WIDTH),
    .IW              (IW)
  ) u_round (
    .i_mag(r_mag),
    .i_e  (r_idx),
    .o_exp(w_exp),
    .o_sat(w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = SEARCH;
      SEARCH:  if (w_hit || (r_idx == '0)) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign   <= 1'b0;
      r_mag    <= '0;
      r_idx    <= '0;
      r_weight <= '0;
      r_zero   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= in_data[IN_BIT_WIDTH-1];
            r_mag  <= w_abs;
            r_idx  <= IW'(IN_BIT_WIDTH - 1);
          end
        end
        SEARCH: begin
          if (w_hit) begin
            r_weight <= {r_sign, w_exp};
            r_zero   <= 1'b0;
            r_sat    <= w_sat;
          end else if (r_idx == '0) begin
            r_weight <= '0;
            r_zero   <= 1'b1;
            r_sat    <= 1'b0;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_weight = r_weight;
  assign out_zero   = r_zero;
  assign out_sat    = r_sat;

endmodule

// File: tb/tb_pot_weight_encoder.sv
// tb/tb_pot_weight_encoder.sv - directed and sweep bench for pot_weight_encoder
module tb_pot_weight_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_weight;
  logic        out_zero;
  logic        out_sat;

  int n_cmp = 0;
  int n_err = 0;

  pot_weight_encoder #(
    .IN_BIT_WIDTH    (12),
    .WEIGHT_BIT_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_weight(out_weight),
    .out_zero  (out_zero),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: nearest power of two, midpoint rounds down.
  function automatic logic [3:0] ref_w(input logic [11:0] d, output logic z,
                                       output logic s, output int lat);
    int   m;
    int   e;
    int   r;
    logic sg;
    sg = d[11];
    m  = sg ? (4096 - int'(d)) : int'(d);
    if (m == 0) begin
      z = 1'b1; s = 1'b0; lat = 12;
      return 4'b0000;
    end
    e = 0;
    while ((1 << (e + 1)) <= m) e++;
    lat = 12 - e;
    r = e;
    if (2 * m > 3 * (1 << e)) r = e + 1;
    if (r > 7) begin r = 7; s = 1'b1; end
    else s = 1'b0;
    z = 1'b0;
    return {sg, 3'(r)};
  endfunction

  task automatic op(input logic [11:0] d, input logic [3:0] ew, input logic ez,
                    input logic es, input int el, input int stall);
    int lat;
    out_ready = (stall == 0);
    in_data   = d;
    in_valid  = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, el);
    check("weight", out_weight, ew);
    check("zero", out_zero, ez);
    check("sat", out_sat, es);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_weight", out_weight, ew);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("xfer_valid_low", out_valid, 0);
    check("xfer_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [3:0] ew;
    logic       ez;
    logic       es;
    int         el;
    int         seen;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_weight", out_weight, 0);
    check("rst_zero", out_zero, 0);
    check("rst_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed vectors, hand-computed.
    op(12'd8,    4'b0011, 1'b0, 1'b0, 9,  0);
    op(12'd13,   4'b0100, 1'b0, 1'b0, 9,  0);
    op(12'hFF4,  4'b1011, 1'b0, 1'b0, 9,  0);  // -12, midpoint
    op(12'hFFD,  4'b1001, 1'b0, 1'b0, 11, 0);  // -3
    op(12'd1,    4'b0000, 1'b0, 1'b0, 12, 0);
    op(12'd0,    4'b0000, 1'b1, 1'b0, 12, 0);
    op(12'd48,   4'b0101, 1'b0, 1'b0, 7,  0);  // midpoint 32/64
    op(12'd255,  4'b0111, 1'b0, 1'b1, 5,  0);  // rounds to 2^8, clipped
    op(12'h800,  4'b1111, 1'b0, 1'b1, 1,  0);  // -2048

    // Backpressure with ignored input while DONE.
    out_ready = 1'b0;
    in_data = 12'd13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    while (out_valid !== 1'b1 && seen < 20) begin @(posedge clk); #1; seen++; end
    check("bp_latency", seen, 9);
    in_data = 12'd5; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_weight", out_weight, 4'b0100);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_single_xfer", out_valid, 0);

    // Reset mid-search: preceding op left sat=1, weight=1111.
    op(12'h800, 4'b1111, 1'b0, 1'b1, 1, 0);
    in_data = 12'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_weight", out_weight, 0);
    check("abort_zero", out_zero, 0);
    check("abort_sat", out_sat, 0);
    check("abort_in_ready", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_output", seen, 0);
    op(12'd100, 4'b0111, 1'b0, 1'b0, 6, 0);  // 100 is nearer 128 than 64

    // Full sweep with random output stalls.
    for (int v = 0; v < 4096; v++) begin
      ew = ref_w(12'(v), ez, es, el);
      op(12'(v), ew, ez, es, el, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
